// File: rtl/fir_output_requant.sv
// fir_output_requant
// Output stage for the pipelined FIR filter. The datapath is:
//   1. Add half an LSB for round-half-up, in ACC_WIDTH+1 bits so the sum cannot wrap.
//   2. Shift right arithmetically, then clip to signed OUT_WIDTH.
//   3. Write into a show-ahead FIFO with a valid/ready read port.
// The FIR cannot be stalled, so a sample that finds the FIFO full is dropped
// and counted. Samples that are clipped and written are also counted.
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   data_in         signed accumulator from the FIR, qualified by data_in_valid
//   data_out        signed requantized sample at the FIFO head (0 when empty)
//   data_out_valid  FIFO non-empty
//   data_out_ready  consumer pops the head when data_out_valid && data_out_ready
//   fifo_level      FIFO occupancy, 0..FIFO_DEPTH
//   sat_count       saturating count of clipped samples that were written
//   drop_count      saturating count of samples lost to a full FIFO
//   overflow_sticky set on the first drop, held until clear_stats
//   clear_stats     synchronous clear of sat_count, drop_count, overflow_sticky
module fir_output_requant #(
    parameter int ACC_WIDTH  = 40,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 15,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ACC_WIDTH-1:0]          data_in,
    input  logic                          data_in_valid,
    output logic [OUT_WIDTH-1:0]          data_out,
    output logic                          data_out_valid,
    input  logic                          data_out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_WIDTH-1:0]          sat_count,
    output logic [CNT_WIDTH-1:0]          drop_count,
    output logic                          overflow_sticky,
    input  logic                          clear_stats
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [ACC_WIDTH:0] ONE   = {{ACC_WIDTH{1'b0}}, 1'b1};
    localparam logic signed [ACC_WIDTH:0] RND   = (SHIFT > 0) ? (ONE <<< RND_POS) : '0;
    localparam logic signed [ACC_WIDTH:0] MAX_V = (ONE <<< (OUT_WIDTH - 1)) - ONE;
    localparam logic signed [ACC_WIDTH:0] MIN_V = -(ONE <<< (OUT_WIDTH - 1));

    // Stage 1: rounding offset added
    logic                        s1_valid_q, s1_valid_d;
    logic signed [ACC_WIDTH:0]   s1_r_q, s1_r_d;
    // Stage 2: shifted and clipped sample
    logic                        s2_valid_q, s2_valid_d;
    logic [OUT_WIDTH-1:0]        s2_data_q, s2_data_d;
    logic                        s2_sat_q, s2_sat_d;
    // FIFO
    logic [OUT_WIDTH-1:0]        mem_q [FIFO_DEPTH];
    logic [AW:0]                 wr_ptr_q, wr_ptr_d;
    logic [AW:0]                 rd_ptr_q, rd_ptr_d;
    // Statistics
    logic [CNT_WIDTH-1:0]        sat_cnt_q, sat_cnt_d;
    logic [CNT_WIDTH-1:0]        drop_cnt_q, drop_cnt_d;
    logic                        ovf_q, ovf_d;

    logic signed [ACC_WIDTH:0]   q_s;
    logic [AW:0]                 level;
    logic                        fifo_empty, fifo_full, pop, wr_en, drop;

    always_comb begin
        s1_valid_d = data_in_valid;
        s1_r_d     = $signed({data_in[ACC_WIDTH-1], data_in}) + RND;

        q_s        = s1_r_q >>> SHIFT;
        s2_valid_d = s1_valid_q;
        s2_sat_d   = 1'b0;
        s2_data_d  = q_s[OUT_WIDTH-1:0];
        if (q_s > MAX_V) begin
            s2_data_d = MAX_V[OUT_WIDTH-1:0];
            s2_sat_d  = 1'b1;
        end else if (q_s < MIN_V) begin
            s2_data_d = MIN_V[OUT_WIDTH-1:0];
            s2_sat_d  = 1'b1;
        end
    end

    always_comb begin
        level      = wr_ptr_q - rd_ptr_q;
        fifo_empty = (level == '0);
        fifo_full  = (level == (AW + 1)'(FIFO_DEPTH));
        pop        = !fifo_empty && data_out_ready;
        // A full FIFO still accepts the write when the head leaves on the same edge
        wr_en      = s2_valid_q && (!fifo_full || pop);
        drop       = s2_valid_q && fifo_full && !pop;

        wr_ptr_d   = wr_en ? wr_ptr_q + (AW + 1)'(1) : wr_ptr_q;
        rd_ptr_d   = pop   ? rd_ptr_q + (AW + 1)'(1) : rd_ptr_q;

        sat_cnt_d  = sat_cnt_q;
        drop_cnt_d = drop_cnt_q;
        ovf_d      = ovf_q;
        if (clear_stats) begin
            sat_cnt_d  = '0;
            drop_cnt_d = '0;
            ovf_d      = 1'b0;
        end else begin
            if (wr_en && s2_sat_q && (sat_cnt_q != '1))
                sat_cnt_d = sat_cnt_q + CNT_WIDTH'(1);
            if (drop && (drop_cnt_q != '1))
                drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
            if (drop)
                ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_r_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_sat_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            sat_cnt_q  <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_r_q     <= s1_r_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_sat_q   <= s2_sat_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            sat_cnt_q  <= sat_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage needs no reset: an entry is only visible once the pointers cover it
    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_ptr_q[AW-1:0]] <= s2_data_q;
    end

    always_comb begin
        data_out_valid  = !fifo_empty;
        data_out        = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
        fifo_level      = level;
        sat_count       = sat_cnt_q;
        drop_count      = drop_cnt_q;
        overflow_sticky = ovf_q;
    end

endmodule
